// File: rtl/psum_accumulator.sv
// Partial-sum stage: re-aligns issue control with the multiplier product word,
// unpacks it into 2 or 4 signed lanes and accumulates each group with saturation.
module psum_accumulator #(
  parameter int ACC_W = 24,
  parameter int LAT   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               iss_valid,
  input  logic               iss_last,
  input  logic               iss_mode,
  input  logic [31:0]        p,
  input  logic               out_ready,
  input  logic               err_clr,
  output logic               out_valid,
  output logic [4*ACC_W-1:0] out_acc,
  output logic               out_mode,
  output logic [15:0]        out_beats,
  output logic [3:0]         out_sat,
  output logic               mode_err,
  output logic               drop_err
);

  typedef enum logic {S_IDLE, S_ACCUM} state_t;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t                  r_state;
  logic [LAT-1:0]          r_dly_vld;
  logic [LAT-1:0]          r_dly_last;
  logic [LAT-1:0]          r_dly_mode;
  logic                    r_grp_mode;

  logic                    w_vld_p0;
  logic                    w_last_p0;
  logic                    w_mode_p0;
  logic                    w_dec_mode_p0;
  logic                    w_finish_p0;
  logic                    w_mode_set_p0;
  logic signed [ACC_W-1:0] w_lane_p0 [4];
  logic [ACC_W:0]          w_sum_p0 [4];
  logic signed [ACC_W-1:0] w_acc_nxt [4];
  logic [3:0]              w_ovf_p0;
  logic [15:0]             w_beats_nxt;
  logic [3:0]              w_sat_nxt;

  logic signed [ACC_W-1:0] r_acc_p1 [4];
  logic [15:0]             r_beats_p1;
  logic [3:0]              r_sat_p1;

  // Returns {overflow, clamped sum}; overflow shows up as disagreeing top two bits.
  function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] a,
                                             input logic signed [ACC_W-1:0] b);
    logic signed [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (s[ACC_W] != s[ACC_W-1])
      return {1'b1, (s[ACC_W] ? ACC_MIN : ACC_MAX)};
    return {1'b0, s[ACC_W-1:0]};
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign w_vld_p0      = r_dly_vld[LAT-1];
  assign w_last_p0     = r_dly_last[LAT-1];
  assign w_mode_p0     = r_dly_mode[LAT-1];
  assign w_finish_p0   = w_vld_p0 && w_last_p0;
  assign w_mode_set_p0 = (r_state == S_ACCUM) && w_vld_p0 && (w_mode_p0 != r_grp_mode);

  // Stage p0: product word aligned with delayed control; decode with the group's mode
  always_comb begin
    w_dec_mode_p0 = (r_state == S_IDLE) ? w_mode_p0 : r_grp_mode;
    w_ovf_p0      = '0;
    for (int k = 0; k < 4; k++) begin
      w_lane_p0[k] = '0;
      w_sum_p0[k]  = '0;
      w_acc_nxt[k] = '0;
    end
    if (w_dec_mode_p0) begin
      for (int k = 0; k < 4; k++)
        w_lane_p0[k] = ACC_W'($signed(p[8*k +: 8]));
    end else begin
      w_lane_p0[0] = ACC_W'($signed(p[15:0]));
      w_lane_p0[1] = ACC_W'($signed(p[31:16]));
    end
    for (int k = 0; k < 4; k++) begin
      if (r_state == S_IDLE) begin
        w_acc_nxt[k] = w_lane_p0[k];
      end else begin
        w_sum_p0[k]  = sat_add(r_acc_p1[k], w_lane_p0[k]);
        w_acc_nxt[k] = w_sum_p0[k][ACC_W-1:0];
        w_ovf_p0[k]  = w_sum_p0[k][ACC_W];
      end
    end
    w_beats_nxt = (r_state == S_IDLE) ? 16'd1 : sat_inc(r_beats_p1);
    w_sat_nxt   = (r_state == S_IDLE) ? 4'd0  : (r_sat_p1 | w_ovf_p0);
  end

  // Stage p1: running group sums
  always_ff @(posedge clk) begin
    if (w_vld_p0) begin
      for (int k = 0; k < 4; k++)
        r_acc_p1[k] <= w_acc_nxt[k];
      r_beats_p1 <= w_beats_nxt;
      r_sat_p1   <= w_sat_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_dly_vld  <= '0;
      r_dly_last <= '0;
      r_dly_mode <= '0;
      r_grp_mode <= 1'b0;
      out_valid  <= 1'b0;
      out_acc    <= '0;
      out_mode   <= 1'b0;
      out_beats  <= '0;
      out_sat    <= '0;
      mode_err   <= 1'b0;
      drop_err   <= 1'b0;
    end else begin
      r_dly_vld[0]  <= iss_valid;
      r_dly_last[0] <= iss_last;
      r_dly_mode[0] <= iss_mode;
      for (int i = 1; i < LAT; i++) begin
        r_dly_vld[i]  <= r_dly_vld[i-1];
        r_dly_last[i] <= r_dly_last[i-1];
        r_dly_mode[i] <= r_dly_mode[i-1];
      end

      if (w_vld_p0) begin
        if (r_state == S_IDLE)
          r_grp_mode <= w_mode_p0;
        r_state <= w_last_p0 ? S_IDLE : S_ACCUM;
      end

      // Stage p2: finished group result held for the consumer
      if (w_finish_p0) begin
        out_valid <= 1'b1;
        out_mode  <= w_dec_mode_p0;
        out_beats <= w_beats_nxt;
        out_sat   <= w_sat_nxt;
        for (int k = 0; k < 4; k++)
          out_acc[k*ACC_W +: ACC_W] <= w_acc_nxt[k];
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (w_mode_set_p0)
        mode_err <= 1'b1;
      else if (err_clr)
        mode_err <= 1'b0;

      if (w_finish_p0 && out_valid && !out_ready)
        drop_err <= 1'b1;
      else if (err_clr)
        drop_err <= 1'b0;
    end
  end

endmodule
